// File: rtl/ov5640_dvp_capture.sv
// ov5640_dvp_capture
//   Camera-domain front end for the OV5640 DVP port. Registers the 8-bit bus
//   once, pairs bytes into RGB565 pixels, expands them to RGB888 and emits a
//   pixel stream with aligned hsync/vsync. Start-up frames are discarded, and
//   line-length, frame-height and byte-pairing faults are latched.
//
// Ports
//   cam_clk        camera pixel clock, the only clock
//   cam_rst        asynchronous active-high reset
//   cam_data[7:0]  DVP data byte
//   cam_href       line-active qualifier
//   cam_vsync      frame sync
//   m_data[23:0]   RGB888 pixel {R,G,B}; holds its value between pixels
//   m_valid        one-cycle pixel strobe
//   m_hsync        line-active, aligned to the pixel stream
//   m_vsync        frame sync, aligned to the pixel stream
//   stream_en      high once FRAME_SKIP frames have passed
//   frame_cnt      frames output while enabled (wrapping)
//   err_line_len   sticky: a line did not carry H_ACTIVE pixels
//   err_frame_len  sticky: a frame did not carry V_ACTIVE lines
//   err_odd_byte   sticky: href fell with half a pixel pending
module ov5640_dvp_capture #(
  parameter int FRAME_SKIP = 10,
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720
) (
  input  logic        cam_clk,
  input  logic        cam_rst,
  input  logic [7:0]  cam_data,
  input  logic        cam_href,
  input  logic        cam_vsync,
  output logic [23:0] m_data,
  output logic        m_valid,
  output logic        m_hsync,
  output logic        m_vsync,
  output logic        stream_en,
  output logic [15:0] frame_cnt,
  output logic        err_line_len,
  output logic        err_frame_len,
  output logic        err_odd_byte
);

  localparam int SKIP_W = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;

  function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] p);
    // Replicate the MSBs into the new LSBs so full-scale maps to 0xFF.
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  // Input stage (s1) and one further delay used for edge detection.
  logic [7:0]        data_s1_q;
  logic              href_s1_q, vsync_s1_q;
  logic              href_s2_q, vsync_s2_q;

  logic              phase_q,        phase_d;
  logic [7:0]        hi_q,           hi_d;
  logic [SKIP_W-1:0] skip_cnt_q,     skip_cnt_d;
  logic              stream_en_q,    stream_en_d;
  logic [11:0]       pix_cnt_q,      pix_cnt_d;
  logic [10:0]       line_cnt_q,     line_cnt_d;
  logic [15:0]       frame_cnt_q,    frame_cnt_d;
  logic [23:0]       m_data_q,       m_data_d;
  logic              m_valid_q,      m_valid_d;
  logic              m_hsync_q,      m_hsync_d;
  logic              m_vsync_q,      m_vsync_d;
  logic              err_line_len_q, err_line_len_d;
  logic              err_frame_q,    err_frame_d;
  logic              err_odd_q,      err_odd_d;

  logic vs_rise, hr_fall, pix_fire;

  always_comb begin
    // NOTE: every combinational output is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    vs_rise        = vsync_s1_q & ~vsync_s2_q;
    hr_fall        = ~href_s1_q & href_s2_q;
    skip_cnt_d     = skip_cnt_q;
    stream_en_d    = stream_en_q;

    // Enable only ever changes on a frame start, so no partial frame leaks out.
    if (vs_rise && !stream_en_q) begin
      if (skip_cnt_q == SKIP_W'(FRAME_SKIP)) stream_en_d = 1'b1;
      else                                   skip_cnt_d  = skip_cnt_q + 1'b1;
    end

    phase_d   = href_s1_q ? ~phase_q : 1'b0;
    hi_d      = (href_s1_q && !phase_q) ? data_s1_q : hi_q;
    pix_fire  = href_s1_q & phase_q & stream_en_d;

    m_valid_d = pix_fire;
    m_data_d  = pix_fire ? rgb565_to_rgb888({hi_q, data_s1_q}) : m_data_q;
    m_hsync_d = stream_en_d & href_s1_q;
    m_vsync_d = stream_en_d & vsync_s1_q;

    pix_cnt_d   = hr_fall ? 12'd0 : pix_cnt_q + {11'd0, pix_fire};
    line_cnt_d  = (vs_rise ? 11'd0 : line_cnt_q) + {10'd0, hr_fall};
    frame_cnt_d = frame_cnt_q + {15'd0, vs_rise & stream_en_d};

    // Checks use the enable already in force, so the frame-height check is
    // skipped at the first enabled frame start (no prior enabled frame).
    err_line_len_d = err_line_len_q |
                     (hr_fall & stream_en_q & (pix_cnt_q != 12'(H_ACTIVE)));
    err_odd_d      = err_odd_q | (hr_fall & stream_en_q & phase_q);
    err_frame_d    = err_frame_q |
                     (vs_rise & stream_en_q & (line_cnt_q != 11'(V_ACTIVE)));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge cam_clk or posedge cam_rst) begin
    if (cam_rst) begin
      data_s1_q      <= '0;
      href_s1_q      <= 1'b0;
      vsync_s1_q     <= 1'b0;
      href_s2_q      <= 1'b0;
      vsync_s2_q     <= 1'b0;
      phase_q        <= 1'b0;
      hi_q           <= '0;
      skip_cnt_q     <= '0;
      stream_en_q    <= 1'b0;
      pix_cnt_q      <= '0;
      line_cnt_q     <= '0;
      frame_cnt_q    <= '0;
      m_data_q       <= '0;
      m_valid_q      <= 1'b0;
      m_hsync_q      <= 1'b0;
      m_vsync_q      <= 1'b0;
      err_line_len_q <= 1'b0;
      err_frame_q    <= 1'b0;
      err_odd_q      <= 1'b0;
    end else begin
      data_s1_q      <= cam_data;
      href_s1_q      <= cam_href;
      vsync_s1_q     <= cam_vsync;
      href_s2_q      <= href_s1_q;
      vsync_s2_q     <= vsync_s1_q;
      phase_q        <= phase_d;
      hi_q           <= hi_d;
      skip_cnt_q     <= skip_cnt_d;
      stream_en_q    <= stream_en_d;
      pix_cnt_q      <= pix_cnt_d;
      line_cnt_q     <= line_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      m_data_q       <= m_data_d;
      m_valid_q      <= m_valid_d;
      m_hsync_q      <= m_hsync_d;
      m_vsync_q      <= m_vsync_d;
      err_line_len_q <= err_line_len_d;
      err_frame_q    <= err_frame_d;
      err_odd_q      <= err_odd_d;
    end
  end

  assign m_data        = m_data_q;
  assign m_valid       = m_valid_q;
  assign m_hsync       = m_hsync_q;
  assign m_vsync       = m_vsync_q;
  assign stream_en     = stream_en_q;
  assign frame_cnt     = frame_cnt_q;
  assign err_line_len  = err_line_len_q;
  assign err_frame_len = err_frame_q;
  assign err_odd_byte  = err_odd_q;

endmodule
